hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Control end of the pipeline forwarding network: tracks in-flight register writes in E/M/W and drives the select inputs of the D, E and M forwarding muxes.
- Raises a stall when a consumer in D needs an operand before its producer can supply it.
- Includes a multiply/divide busy counter that stalls HI/LO-dependent instructions.
- Sits beside the pipeline registers; D-stage decode feeds it, the datapath muxes consume its outputs.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- rs_D, rt_D  in  5 each  source register numbers of the instruction in D.
- tuse_rs_D, tuse_rt_D  in  2 each  cycles until operand is needed (0–2; 3 = unused).
- a3_D  in  5  destination register of the instruction in D (0 = no write).
- tnew_D  in  2  cycles until result is ready, measured at E entry.
- res_D  in  3  result class: 0 NONE, 1 ALU, 2 DM, 3 PC8, 4 XALU.
- md_start_E  in  1  mult/div begins in E this cycle.
- md_div_E  in  1  the started op is a divide.
- md_use_D  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
- stall  out  1  hold PC and D register, insert a bubble into E.
- fwd_rs_D, fwd_rt_D  out  3 each  D mux select: 0 PRE, 1 ALUOUT_M, 2 PC8_M, 3 XALUOUT_M.
- fwd_rs_E, fwd_rt_E  out  3 each  E mux select: 0 PRE, 1 ALUOUT_M, 2 mux_Wdata, 3 PC8_M, 4 PC8_W, 5 XALUOUT_M, 6 XALUOUT_W.
- fwd_rt_M  out  2  M mux select: 0 PRE, 1 mux_Wdata, 2 PC8_W, 3 XALUOUT_W.

Behaviour:
- Internal pipeline state per stage X ∈ {E, M, W}: rs, rt, a3, tnew, res. E additionally holds rs/rt. M holds rt.
- Rising edge, reset low: all stage registers cleared (a3=0, res=NONE, tnew=0) and MD counter cleared. stall and all fwd_* are 0 one cycle later, since they are combinational from the cleared state.
- Normal edge: W<=M; M<=E with tnew_M = (tnew_E==0)?0:tnew_E-1; E<=D fields.
- Edge with stall=1: E is loaded with a bubble (all zero); M and W advance normally.
- Register 0 never matches and never forwards or stalls.
- Match condition: reg != 0, reg == a3_X, res_X != NONE.
- D forwarding: forward only from M, and only when tnew_M==0. Result class maps ALU→1, PC8→2, XALU→3. DM is never forwarded from M. W→D needs no select because the GRF write is visible to a same-cycle read.
- E forwarding (M has priority over W):
  - M with tnew_M==0: ALU→1, PC8→3, XALU→5.
  - Else W: ALU/DM→2, PC8→4, XALU→6.
  - Else 0.
- M forwarding (rt_M only) from W: ALU/DM→1, PC8→2, XALU→3; else 0.
- Data stall for operand rs (rt identical):
  - Stall when rs_D matches E and tnew_E > tuse_rs_D.
  - Or when rs_D matches M and tnew_M > tuse_rs_D.
  - tuse=3 never stalls.
- MD counter:
  - On md_start_E it loads MULT_CYCLES or DIV_CYCLES.
  - Otherwise it decrements while nonzero. busy = (cnt != 0).
  - A start during busy reloads the counter.
  - md_stall = md_use_D & (busy | md_start_E).
- stall = data_stall | md_stall. It is purely combinational; there is no latency from input to stall.
- Reset asserted mid-divide aborts the count; the next cycle has busy=0.

Optional Feature:
- Macro HAZARD_STAT_EN.
- Defined: adds output stall_cnt (32 bit), cleared on reset and incremented on every cycle with stall=1. It wraps at 2^32-1 → 0. It also adds output md_stall_cnt (32 bit) with the same rules, counting md_stall.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mips_hazard_pkg holds:
  - result-class codes (RES_NONE/ALU/DM/PC8/XALU);
  - D/E/M select encodings;
  - TUSE_NONE=3.
- Sub-module md_busy_counter holds the MD counter, with parameters MULT_CYCLES and DIV_CYCLES; it produces busy.

Test Plan:
- addu $3 in E (tnew=0, ALU) followed by subu using $3 as rs in D:
  - next cycle, fwd_rs_E=1;
  - cycle after, fwd_rs_E=2;
  - stall=0 throughout.
- lw $5 (DM, tnew=2) in E, beq reading $5 in D (tuse=0) → stall=1 for 2 cycles, then fwd_rs_D=0 once W writes.
- jal (a3=31, PC8, tnew=0) then jr $31 → fwd_rs_D=2 when jal is in M, no stall.
- sw with rt=$7 in M and addu $7 in W → fwd_rt_M=1. Producer a3=0 → all fwd=0.
- div in E (DIV_CYCLES=10) then mflo in D → stall=1 for 11 consecutive cycles, then 0.
- Assert reset during the div count → next cycle stall=0 and all fwd_*=0. With HAZARD_STAT_EN, stall_cnt reads 0 after reset.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller.
// Result classes, mux select codes and per-stage bundles.
package mips_hazard_pkg;

    typedef enum logic [2:0] {
        RES_NONE = 3'd0,
        RES_ALU  = 3'd1,
        RES_DM   = 3'd2,
        RES_PC8  = 3'd3,
        RES_XALU = 3'd4
    } res_e;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [2:0] FD_PRE    = 3'd0;
    localparam logic [2:0] FD_ALU_M  = 3'd1;
    localparam logic [2:0] FD_PC8_M  = 3'd2;
    localparam logic [2:0] FD_XALU_M = 3'd3;

    localparam logic [2:0] FE_PRE    = 3'd0;
    localparam logic [2:0] FE_ALU_M  = 3'd1;
    localparam logic [2:0] FE_WDATA  = 3'd2;
    localparam logic [2:0] FE_PC8_M  = 3'd3;
    localparam logic [2:0] FE_PC8_W  = 3'd4;
    localparam logic [2:0] FE_XALU_M = 3'd5;
    localparam logic [2:0] FE_XALU_W = 3'd6;

    localparam logic [1:0] FM_PRE    = 2'd0;
    localparam logic [1:0] FM_WDATA  = 2'd1;
    localparam logic [1:0] FM_PC8_W  = 2'd2;
    localparam logic [1:0] FM_XALU_W = 2'd3;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic [1:0] tnew;
        res_e       res;
    } e_stage_t;

    typedef struct packed {
        logic [4:0] rt;
        logic [4:0] a3;
        logic [1:0] tnew;
        res_e       res;
    } m_stage_t;

    typedef struct packed {
        logic [4:0] a3;
        res_e       res;
    } w_stage_t;

    function automatic logic reg_hit(
        input logic [4:0] r,
        input logic [4:0] a3,
        input res_e       res
    );
        return (r != 5'd0) && (r == a3) && (res != RES_NONE);
    endfunction

    // Loads are never forwarded out of M; only W can supply them.
    function automatic logic [2:0] sel_d(input res_e res);
        unique case (res)
            RES_ALU:  return FD_ALU_M;
            RES_PC8:  return FD_PC8_M;
            RES_XALU: return FD_XALU_M;
            default:  return FD_PRE;
        endcase
    endfunction

    function automatic logic [2:0] sel_e_m(input res_e res);
        unique case (res)
            RES_ALU:  return FE_ALU_M;
            RES_PC8:  return FE_PC8_M;
            RES_XALU: return FE_XALU_M;
            default:  return FE_PRE;
        endcase
    endfunction

    function automatic logic [2:0] sel_e_w(input res_e res);
        unique case (res)
            RES_ALU:  return FE_WDATA;
            RES_DM:   return FE_WDATA;
            RES_PC8:  return FE_PC8_W;
            RES_XALU: return FE_XALU_W;
            default:  return FE_PRE;
        endcase
    endfunction

    function automatic logic [1:0] sel_m_w(input res_e res);
        unique case (res)
            RES_ALU:  return FM_WDATA;
            RES_DM:   return FM_WDATA;
            RES_PC8:  return FM_PC8_W;
            RES_XALU: return FM_XALU_W;
            default:  return FM_PRE;
        endcase
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// D-stage decode fields in, stall and forwarding selects out.
// master = pipeline/datapath side, slave = hazard controller.
interface hazard_forward_ctrl_if;

    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic [4:0] a3_D;
    logic [1:0] tnew_D;
    logic [2:0] res_D;
    logic       md_start_E;
    logic       md_div_E;
    logic       md_use_D;

    logic       stall;
    logic [2:0] fwd_rs_D;
    logic [2:0] fwd_rt_D;
    logic [2:0] fwd_rs_E;
    logic [2:0] fwd_rt_E;
    logic [1:0] fwd_rt_M;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D,
        output a3_D, tnew_D, res_D,
        output md_start_E, md_div_E, md_use_D,
        input  stall,
        input  fwd_rs_D, fwd_rt_D,
        input  fwd_rs_E, fwd_rt_E, fwd_rt_M
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D,
        input  a3_D, tnew_D, res_D,
        input  md_start_E, md_div_E, md_use_D,
        output stall,
        output fwd_rs_D, fwd_rt_D,
        output fwd_rs_E, fwd_rt_E, fwd_rt_M
    );

endinterface

// File: rtl/hazard_forward_ctrl_md_busy.sv
// Multiply/divide busy counter; a new start always reloads.
// busy is high while the count is nonzero.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int MAX_CYCLES =
        (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forwarding-select control for E/M/W.
// HAZARD_STAT_EN adds stall_cnt and md_stall_cnt outputs.
module hazard_forward_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_forward_ctrl_if.slave bus
`ifdef HAZARD_STAT_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          md_stall_cnt
`endif
);

    e_stage_t e_q;
    m_stage_t m_q;
    w_stage_t w_q;

    logic md_busy;
    logic md_stall;
    logic data_stall;
    logic stall_w;

    function automatic logic op_stall(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input res_e       e_res,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew,
        input res_e       m_res
    );
        if (tuse == TUSE_NONE) begin
            return 1'b0;
        end
        return (reg_hit(r, e_a3, e_res) && (e_tnew > tuse))
            || (reg_hit(r, m_a3, m_res) && (m_tnew > tuse));
    endfunction

    function automatic logic [2:0] fwd_d(
        input logic [4:0] r,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew,
        input res_e       m_res
    );
        if (reg_hit(r, m_a3, m_res) && (m_tnew == 2'd0)) begin
            return sel_d(m_res);
        end
        return FD_PRE;
    endfunction

    // M wins over W, but only when M actually has a forwardable value.
    function automatic logic [2:0] fwd_e(
        input logic [4:0] r,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew,
        input res_e       m_res,
        input logic [4:0] w_a3,
        input res_e       w_res
    );
        logic [2:0] sel;
        sel = FE_PRE;
        if (reg_hit(r, m_a3, m_res) && (m_tnew == 2'd0)) begin
            sel = sel_e_m(m_res);
        end
        if ((sel == FE_PRE) && reg_hit(r, w_a3, w_res)) begin
            sel = sel_e_w(w_res);
        end
        return sel;
    endfunction

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .clk   (clk),
        .reset (reset),
        .start (bus.md_start_E),
        .div   (bus.md_div_E),
        .busy  (md_busy)
    );

    always_comb begin
        data_stall =
            op_stall(bus.rs_D, bus.tuse_rs_D,
                     e_q.a3, e_q.tnew, e_q.res,
                     m_q.a3, m_q.tnew, m_q.res)
          | op_stall(bus.rt_D, bus.tuse_rt_D,
                     e_q.a3, e_q.tnew, e_q.res,
                     m_q.a3, m_q.tnew, m_q.res);
        md_stall = bus.md_use_D & (md_busy | bus.md_start_E);
        stall_w  = data_stall | md_stall;
    end

    assign bus.stall    = stall_w;
    assign bus.fwd_rs_D = fwd_d(bus.rs_D, m_q.a3, m_q.tnew, m_q.res);
    assign bus.fwd_rt_D = fwd_d(bus.rt_D, m_q.a3, m_q.tnew, m_q.res);
    assign bus.fwd_rs_E = fwd_e(e_q.rs, m_q.a3, m_q.tnew, m_q.res,
                                w_q.a3, w_q.res);
    assign bus.fwd_rt_E = fwd_e(e_q.rt, m_q.a3, m_q.tnew, m_q.res,
                                w_q.a3, w_q.res);
    assign bus.fwd_rt_M = reg_hit(m_q.rt, w_q.a3, w_q.res)
                        ? sel_m_w(w_q.res) : FM_PRE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q.a3   <= m_q.a3;
            w_q.res  <= m_q.res;
            m_q.rt   <= e_q.rt;
            m_q.a3   <= e_q.a3;
            m_q.res  <= e_q.res;
            m_q.tnew <= (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
            if (stall_w) begin
                e_q <= '0;
            end else begin
                e_q <= '{rs:   bus.rs_D,
                         rt:   bus.rt_D,
                         a3:   bus.a3_D,
                         tnew: bus.tnew_D,
                         res:  res_e'(bus.res_D)};
            end
        end
    end

`ifdef HAZARD_STAT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall_w) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (md_stall) begin
                md_stall_cnt <= md_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed table, multi-cycle MD/reset sequences, then random
// stimulus against an age-based pipeline occupancy model.
module tb_hazard_forward_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_forward_ctrl_if bus ();

`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt;
    logic [31:0] md_stall_cnt;
`endif

    hazard_forward_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef HAZARD_STAT_EN
        ,
        .stall_cnt    (stall_cnt),
        .md_stall_cnt (md_stall_cnt)
`endif
    );

    typedef struct {
        int rs;
        int rt;
        int tuse_rs;
        int tuse_rt;
        int a3;
        int tnew;
        int res;
    } ins_t;

    typedef struct {
        ins_t d;
        int   st;
        int   fd_rs;
        int   fd_rt;
        int   fe_rs;
        int   fe_rt;
        int   fm_rt;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Select codes indexed by result class NONE/ALU/DM/PC8/XALU.
    int d_map[5]   = '{0, 1, 0, 2, 3};
    int e_m_map[5] = '{0, 1, 0, 3, 5};
    int e_w_map[5] = '{0, 2, 2, 4, 6};
    int m_w_map[5] = '{0, 1, 1, 2, 3};

    ins_t pipe[3];
    int   cyc;
    int   busy_until;
    int   exp_st_cnt;
    int   exp_md_cnt;

    function automatic ins_t mk(int rs, int rt, int tr, int tt,
                                int a3, int tn, int res);
        ins_t i;
        i.rs = rs; i.rt = rt; i.tuse_rs = tr; i.tuse_rt = tt;
        i.a3 = a3; i.tnew = tn; i.res = res;
        return i;
    endfunction

    function automatic vec_t vv(ins_t d, int st, int fdrs, int fdrt,
                                int fers, int fert, int fmrt);
        vec_t v;
        v.d = d; v.st = st; v.fd_rs = fdrs; v.fd_rt = fdrt;
        v.fe_rs = fers; v.fe_rt = fert; v.fm_rt = fmrt;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int st,
                              input int fdrs, input int fdrt,
                              input int fers, input int fert,
                              input int fmrt);
        check({tag, " stall"},    int'(bus.stall),    st);
        check({tag, " fwd_rs_D"}, int'(bus.fwd_rs_D), fdrs);
        check({tag, " fwd_rt_D"}, int'(bus.fwd_rt_D), fdrt);
        check({tag, " fwd_rs_E"}, int'(bus.fwd_rs_E), fers);
        check({tag, " fwd_rt_E"}, int'(bus.fwd_rt_E), fert);
        check({tag, " fwd_rt_M"}, int'(bus.fwd_rt_M), fmrt);
    endtask

    task automatic drive(input ins_t d, input bit st, input bit dv,
                         input bit mu);
        bus.rs_D       = 5'(d.rs);
        bus.rt_D       = 5'(d.rt);
        bus.tuse_rs_D  = 2'(d.tuse_rs);
        bus.tuse_rt_D  = 2'(d.tuse_rt);
        bus.a3_D       = 5'(d.a3);
        bus.tnew_D     = 2'(d.tnew);
        bus.res_D      = 3'(d.res);
        bus.md_start_E = st;
        bus.md_div_E   = dv;
        bus.md_use_D   = mu;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Remaining result latency of the instruction j stages past E.
    function automatic int remaining(int j);
        return (pipe[j].tnew > j) ? pipe[j].tnew - j : 0;
    endfunction

    function automatic bit produces(int r, int j);
        return r != 0 && r == pipe[j].a3 && pipe[j].res != 0;
    endfunction

    function automatic int m_exp_stall(ins_t d);
        int st;
        st = 0;
        for (int j = 0; j < 2; j++) begin
            if (d.tuse_rs != 3 && produces(d.rs, j)
                && remaining(j) > d.tuse_rs) st = 1;
            if (d.tuse_rt != 3 && produces(d.rt, j)
                && remaining(j) > d.tuse_rt) st = 1;
        end
        return st;
    endfunction

    function automatic int m_exp_d(int r);
        if (produces(r, 1) && remaining(1) == 0) return d_map[pipe[1].res];
        return 0;
    endfunction

    function automatic int m_exp_e(int r);
        if (produces(r, 1) && remaining(1) == 0
            && e_m_map[pipe[1].res] != 0) return e_m_map[pipe[1].res];
        if (produces(r, 2)) return e_w_map[pipe[2].res];
        return 0;
    endfunction

    function automatic int m_exp_m();
        if (produces(pipe[1].rt, 2)) return m_w_map[pipe[2].res];
        return 0;
    endfunction

    vec_t tbl[$];
    ins_t nop;
    ins_t mflo;
    ins_t zero_ins;

    initial begin
        nop      = mk(0, 0, 3, 3, 0, 0, 0);
        mflo     = mk(0, 0, 3, 3, 8, 1, 4);
        zero_ins = mk(0, 0, 0, 0, 0, 0, 0);

        // addu $3 -> subu/or reading $3
        tbl.push_back(vv(mk(1, 2, 1, 1, 3, 0, 1), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(3, 0, 1, 3, 4, 0, 1), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(3, 0, 1, 3, 5, 0, 1), 0, 1, 0, 1, 0, 0));
        tbl.push_back(vv(nop,                     0, 0, 0, 2, 0, 0));
        tbl.push_back(vv(nop,                     0, 0, 0, 0, 0, 0));
        // lw $5 -> beq $5
        tbl.push_back(vv(mk(1, 0, 1, 3, 5, 2, 2), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(5, 0, 0, 3, 0, 0, 0), 1, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(5, 0, 0, 3, 0, 0, 0), 1, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(5, 0, 0, 3, 0, 0, 0), 0, 0, 0, 0, 0, 0));
        // lw $6 -> reader with tuse=3
        tbl.push_back(vv(mk(0, 0, 3, 3, 6, 2, 2), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(6, 6, 3, 3, 0, 0, 0), 0, 0, 0, 0, 0, 0));
        // jal, slot, jr $31
        tbl.push_back(vv(mk(0, 0, 3, 3, 31, 0, 3), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(nop,                      0, 0, 0, 0, 0, 1));
        tbl.push_back(vv(mk(31, 0, 0, 3, 0, 0, 0), 0, 2, 0, 0, 0, 0));
        tbl.push_back(vv(nop,                      0, 0, 0, 4, 0, 0));
        // addu $7 -> sw rt=$7
        tbl.push_back(vv(mk(1, 2, 1, 1, 7, 0, 1), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(1, 7, 1, 2, 0, 0, 0), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(nop,                     0, 0, 0, 0, 1, 0));
        tbl.push_back(vv(nop,                     0, 0, 0, 0, 0, 1));
        // XALU $9 consumers
        tbl.push_back(vv(mk(0, 0, 3, 3, 9, 1, 4), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(9, 9, 1, 2, 0, 0, 0), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(9, 0, 0, 3, 0, 0, 0), 0, 3, 0, 5, 5, 0));
        tbl.push_back(vv(nop,                     0, 0, 0, 6, 0, 3));
        // jal -> sw rt=$31
        tbl.push_back(vv(mk(0, 0, 3, 3, 31, 0, 3), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(0, 31, 3, 2, 0, 0, 0), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(nop,                      0, 0, 0, 0, 3, 0));
        tbl.push_back(vv(nop,                      0, 0, 0, 0, 0, 2));
        // producer a3=0, reader of $0
        tbl.push_back(vv(mk(1, 2, 1, 1, 0, 0, 1), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(nop,                     0, 0, 0, 0, 0, 0));
        // lw $11 -> rt consumer tuse=1
        tbl.push_back(vv(mk(0, 0, 3, 3, 11, 2, 2), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(0, 11, 3, 1, 0, 0, 0), 1, 0, 0, 0, 0, 0));
        tbl.push_back(vv(mk(0, 11, 3, 1, 0, 0, 0), 0, 0, 0, 0, 0, 0));
        tbl.push_back(vv(nop,                      0, 0, 0, 0, 2, 0));

        reset = 1'b0;
        drive(nop, 0, 0, 0);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check_outs("reset", 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STAT_EN
        check("reset stall_cnt", int'(stall_cnt), 0);
`endif
        next_cycle();

        foreach (tbl[i]) begin
            drive(tbl[i].d, 0, 0, 0);
            @(negedge clk);
            check_outs($sformatf("row%0d", i), tbl[i].st,
                       tbl[i].fd_rs, tbl[i].fd_rt,
                       tbl[i].fe_rs, tbl[i].fe_rt, tbl[i].fm_rt);
            next_cycle();
        end

        // div in E, mflo waiting in D: start cycle plus DIV_N busy cycles
        drive(mflo, 1, 1, 1);
        @(negedge clk);
        check("div start stall", int'(bus.stall), 1);
        next_cycle();
        for (int i = 1; i <= DIV_N; i++) begin
            drive(mflo, 0, 0, 1);
            @(negedge clk);
            check($sformatf("div busy%0d stall", i), int'(bus.stall), 1);
            next_cycle();
        end
        drive(mflo, 0, 0, 1);
        @(negedge clk);
        check("div done stall", int'(bus.stall), 0);
`ifdef HAZARD_STAT_EN
        check("div stall_cnt", int'(stall_cnt), 14);
        check("div md_stall_cnt", int'(md_stall_cnt), DIV_N + 1);
`endif
        next_cycle();

        // reset part-way through a divide
        drive(mflo, 1, 1, 1);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(mflo, 0, 0, 1);
            next_cycle();
        end
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        drive(mk(8, 8, 0, 0, 0, 0, 0), 0, 0, 1);
        @(negedge clk);
        check_outs("md reset", 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STAT_EN
        check("md reset stall_cnt", int'(stall_cnt), 0);
        check("md reset md_stall_cnt", int'(md_stall_cnt), 0);
`endif
        next_cycle();

        // random phase from a clean reset
        reset = 1'b0;
        drive(nop, 0, 0, 0);
        next_cycle();
        reset = 1'b1;
        for (int j = 0; j < 3; j++) pipe[j] = zero_ins;
        cyc        = 0;
        busy_until = -1;
        exp_st_cnt = 0;
        exp_md_cnt = 0;

        for (int n = 0; n < 3000; n++) begin
            ins_t d;
            bit   st;
            bit   dv;
            bit   mu;
            bit   rst_n;
            int   e_st;
            int   e_md;
            int   e_stall;
            d = mk($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 4));
            st    = ($urandom_range(0, 5) == 0);
            dv    = $urandom_range(0, 1) == 1;
            mu    = ($urandom_range(0, 2) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            drive(d, st, dv, mu);
            reset = rst_n;

            e_md    = (mu && (st || cyc <= busy_until)) ? 1 : 0;
            e_st    = m_exp_stall(d);
            e_stall = (e_st != 0 || e_md != 0) ? 1 : 0;

            @(negedge clk);
            check_outs($sformatf("rnd%0d", n), e_stall,
                       m_exp_d(d.rs), m_exp_d(d.rt),
                       m_exp_e(pipe[0].rs), m_exp_e(pipe[0].rt),
                       m_exp_m());
`ifdef HAZARD_STAT_EN
            check($sformatf("rnd%0d stall_cnt", n),
                  int'(stall_cnt), exp_st_cnt);
            check($sformatf("rnd%0d md_stall_cnt", n),
                  int'(md_stall_cnt), exp_md_cnt);
`endif
            @(posedge clk);
            if (!rst_n) begin
                for (int j = 0; j < 3; j++) pipe[j] = zero_ins;
                busy_until = -1;
                exp_st_cnt = 0;
                exp_md_cnt = 0;
            end else begin
                exp_st_cnt += e_stall;
                exp_md_cnt += e_md;
                if (st) busy_until = cyc + (dv ? DIV_N : MULT_N);
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = (e_stall != 0) ? zero_ins : d;
            end
            cyc++;
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
